swervolf_uart_sink: RTL and testbench



---
 rtl/swervolf_uart_pkg.sv | 22 ++
 rtl/uart_sink_fifo.sv | 56 +++++
 rtl/swervolf_uart_sink.sv | 151 +++++++++++++++
 tb/tb_swervolf_uart_sink.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swervolf_uart_pkg.sv
// rtl/swervolf_uart_pkg.sv - shared constants, state encoding and baud divider helpers for the UART sink
package swervolf_uart_pkg;

    localparam int unsigned DEFAULT_BAUD = 115200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic int unsigned baud_half(input int unsigned clk_hz, input int unsigned baud);
        return baud_div(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_sink_fifo.sv
// rtl/uart_sink_fifo.sv - synchronous FIFO with separate occupancy count, no fall-through
module uart_sink_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/swervolf_uart_sink.sv
// rtl/swervolf_uart_sink.sv - UART receiver with synchronizer, framing check and byte FIFO stream output
module swervolf_uart_sink
    import swervolf_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 32'd50_000_000,
    parameter int unsigned BAUD        = DEFAULT_BAUD,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_rx,
    output logic [7:0]                          o_data,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic                                o_frame_err,
    output logic                                o_overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_level
);
    localparam int unsigned DIV  = baud_div(CLK_FREQ_HZ, BAUD);
    localparam int unsigned HALF = baud_half(CLK_FREQ_HZ, BAUD);
    localparam int unsigned CW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    logic          rx_meta;
    logic          rx_s;
    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, idx_n;
    logic [7:0]    shreg, sh_n;
    logic          push_pend, push_n;
    logic          err_pend, err_n;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    assign o_valid = !fifo_empty;
    assign pop     = o_valid && i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = bit_idx;
        sh_n    = shreg;
        push_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_n   = HALF_M1;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (cnt == '0) begin
                    if (!rx_s) begin
                        cnt_n   = DIV_M1;
                        idx_n   = 3'd0;
                        state_n = ST_DATA;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt == '0) begin
                    sh_n  = {rx_s, shreg[7:1]};
                    cnt_n = DIV_M1;
                    idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = ST_STOP;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt == '0) begin
                    if (rx_s) begin
                        push_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = ST_BREAK;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Push and error are staged one cycle so both surface at the same offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            push_pend   <= 1'b0;
            err_pend    <= 1'b0;
            o_frame_err <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= idx_n;
            shreg       <= sh_n;
            push_pend   <= push_n;
            err_pend    <= err_n;
            o_frame_err <= err_pend;
            if (push_pend && fifo_full && !pop) begin
                o_overflow <= 1'b1;
            end
        end
    end

    uart_sink_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_pend),
        .push_data (shreg),
        .pop       (pop),
        .pop_data  (o_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (o_level)
    );

endmodule

// File: tb/tb_swervolf_uart_sink.sv
// tb/tb_swervolf_uart_sink.sv - self-checking bench for swervolf_uart_sink
module tb_swervolf_uart_sink;

    localparam int unsigned CLK_HZ  = 1_700_000;
    localparam int unsigned BAUD_S  = 100_000;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned DIV     = CLK_HZ / BAUD_S;
    localparam int unsigned HALF    = DIV / 2;
    localparam int unsigned LAT     = 3 + HALF + 9 * DIV;
    localparam int unsigned DIV_DEF = 434;
    localparam int unsigned LAT_DEF = 4126;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovf;
    logic [4:0] level;

    logic       rx_d = 1'b1;
    logic       ready_d = 1'b1;
    logic [7:0] data_d;
    logic       valid_d;
    logic       ferr_d;
    logic       ovf_d;
    logic [4:0] level_d;

    always #5 clk = ~clk;

    swervolf_uart_sink #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD_S),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (rx),
        .o_data      (data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_frame_err (ferr),
        .o_overflow  (ovf),
        .o_level     (level)
    );

    swervolf_uart_sink dut_def (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (rx_d),
        .o_data      (data_d),
        .o_valid     (valid_d),
        .i_ready     (ready_d),
        .o_frame_err (ferr_d),
        .o_overflow  (ovf_d),
        .o_level     (level_d)
    );

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         start_cyc;
    int         start_def;
    logic [7:0] got[$];
    logic [7:0] expq[$];
    int         err_pulses;
    int         err_cyc;
    int         rise_cyc;
    int         valid_cycles;
    int         rise_def;
    int         def_cycles;
    int         def_err;
    logic [7:0] def_data;
    logic       pv = 1'b0;
    logic       pvd = 1'b0;
    logic       rnd_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are observed half a cycle before the edge that performs them.
    always @(negedge clk) begin
        if (valid && ready) got.push_back(data);
        if (ferr) begin
            err_pulses++;
            err_cyc = cyc;
        end
        if (valid && !pv) rise_cyc = cyc;
        if (valid) valid_cycles++;
        pv = valid;
        if (valid_d && !pvd) begin
            rise_def = cyc;
            def_data = data_d;
        end
        if (valid_d) def_cycles++;
        if (ferr_d) def_err++;
        pvd = valid_d;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_ready) ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        start_cyc = cyc + 1;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(DIV);
        end
        rx = stop;
        tick(DIV);
        rx = 1'b1;
    endtask

    task automatic send_def(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        start_def = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            rx_d = frame[i];
            repeat (DIV_DEF) @(posedge clk);
            #1;
        end
        rx_d = 1'b1;
    endtask

    task automatic clear_mon();
        got.delete();
        err_pulses   = 0;
        err_cyc      = -1;
        rise_cyc     = -1;
        valid_cycles = 0;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       exp_err;
        logic       exp_byte;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'hA3, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h01, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        tick(3);
        check("rst_valid", valid, 0);
        check("rst_level", level, 0);
        check("rst_ferr", ferr, 0);
        check("rst_ovf", ovf, 0);
        check("rst_data", data, 8'h00);
        check("rst_def_valid", valid_d, 0);
        rst = 1'b0;
        tick(3);

        // Default-rate instance: 0x55 latency and single-cycle valid.
        def_cycles = 0;
        def_err    = 0;
        rise_def   = -1;
        send_def(8'h55);
        tick(10);
        check("def_latency", rise_def - start_def, LAT_DEF);
        check("def_data", def_data, 8'h55);
        check("def_valid_cycles", def_cycles, 1);
        check("def_ferr", def_err, 0);

        // Table-driven single frames with consumer always ready.
        ready = 1'b1;
        foreach (vecs[k]) begin
            clear_mon();
            send_byte(vecs[k].b, vecs[k].stop);
            tick(4);
            check("tbl_count", got.size(), vecs[k].exp_byte ? 1 : 0);
            check("tbl_err", err_pulses, vecs[k].exp_err ? 1 : 0);
            check("tbl_level", level, 0);
            if (vecs[k].exp_byte) begin
                if (got.size() > 0) check("tbl_data", got[0], vecs[k].b);
                check("tbl_latency", rise_cyc - start_cyc, LAT);
                check("tbl_valid_cycles", valid_cycles, 1);
            end else begin
                check("tbl_err_latency", err_cyc - start_cyc, LAT);
            end
        end

        // Start-bit glitch shorter than half a bit.
        clear_mon();
        rx = 1'b0;
        tick(HALF - 3);
        rx = 1'b1;
        tick(3 * DIV);
        check("glitch_count", got.size(), 0);
        check("glitch_err", err_pulses, 0);
        check("glitch_level", level, 0);
        send_byte(8'h5A, 1'b1);
        tick(4);
        check("post_glitch_count", got.size(), 1);
        if (got.size() > 0) check("post_glitch_data", got[0], 8'h5A);

        // Overflow: 17 back-to-back frames into a 16-deep FIFO.
        ready = 1'b0;
        clear_mon();
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
        tick(5);
        check("ovf_level", level, 16);
        check("ovf_flag", ovf, 1);
        ready = 1'b1;
        tick(20);
        ready = 1'b0;
        check("ovf_drain_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) check("ovf_drain_data", got[i], i);
        check("ovf_sticky", ovf, 1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("ovf_cleared", ovf, 0);

        // Full FIFO with push and pop on the same edge.
        clear_mon();
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b1);
        tick(3);
        check("full_level", level, 16);
        fork
            send_byte(8'hEE, 1'b1);
            begin
                repeat (LAT) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
            end
        join
        tick(3);
        check("simul_level", level, 16);
        check("simul_ovf", ovf, 0);
        check("simul_popped", got.size(), 1);
        ready = 1'b1;
        tick(20);
        check("simul_drain_count", got.size(), 17);
        for (int i = 0; i < 16 && i < got.size(); i++) check("simul_drain_data", got[i], 8'h20 + i);
        if (got.size() == 17) check("simul_last", got[16], 8'hEE);

        // Reset while data bit 4 is on the line.
        clear_mon();
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (5 * DIV + DIV / 2) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        tick(5);
        check("midrst_count", got.size(), 0);
        check("midrst_level", level, 0);
        send_byte(8'h7E, 1'b1);
        tick(4);
        check("midrst_next_count", got.size(), 1);
        if (got.size() > 0) check("midrst_next_data", got[0], 8'h7E);
        check("midrst_err", err_pulses, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_ferr", ferr, 0);

        // Random bytes, random gaps, random consumer stalls.
        clear_mon();
        expq.delete();
        rnd_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            expq.push_back(b);
            send_byte(b, 1'b1);
            tick($urandom_range(0, 2 * DIV));
        end
        rnd_ready = 1'b0;
        ready = 1'b1;
        tick(30);
        check("rnd_count", got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++) check("rnd_data", got[i], expq[i]);
        check("rnd_err", err_pulses, 0);
        check("rnd_ovf", ovf, 0);
        check("rnd_level", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
